// File: rtl/router_pkg.sv
// Shared types and constants for the router egress arbiter: FSM states,
// channel count, header field positions and the round-robin step helper.
package router_pkg;

  typedef enum logic [2:0] {
    ARB,
    RD_HDR,
    CAP_HDR,
    RD_BODY,
    LAST
  } state_t;

  localparam int NUM_CH = 3;
  localparam logic [1:0] GRANT_NONE = 2'd3;

  // Header length field sits in bits [DW-1:2]; the two LSBs carry the address.
  localparam int DW_DEF  = 8;
  localparam int LEN_MSB = DW_DEF - 1;
  localparam int LEN_LSB = 2;

  // Width of the stall counter; TIMEOUT must fit below 2**CNT_W.
  localparam int CNT_W = 16;

  function automatic logic [1:0] next_ch(input logic [1:0] ch);
    return (ch >= 2'd2) ? 2'd0 : ch + 2'd1;
  endfunction

endpackage

// File: rtl/rr_pick3.sv
// Combinational three-way round-robin picker: searches req starting one past
// last_grant and reports the first requesting channel.
module rr_pick3
  import router_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  logic [1:0]        last_grant,
  output logic              found,
  output logic [1:0]        idx
);

  logic [1:0] cand0;
  logic [1:0] cand1;
  logic [1:0] cand2;

  always_comb begin
    cand0 = next_ch(last_grant);
    cand1 = next_ch(cand0);
    cand2 = next_ch(cand1);
    found = 1'b1;
    idx   = cand0;
    if (req[cand0]) begin
      idx = cand0;
    end else if (req[cand1]) begin
      idx = cand1;
    end else if (req[cand2]) begin
      idx = cand2;
    end else begin
      found = 1'b0;
    end
  end

endmodule

// File: rtl/router_egress_arbiter.sv
// Packet-atomic round-robin arbiter merging three router FIFOs onto one egress
// byte stream, with a stall timeout that drops a grant whose FIFO ran dry.
//
// Handshake: ready_in=1 in a cycle promises the sink takes a byte in the next
// cycle. A FIFO read is issued only in a cycle with ready_in=1 and the granted
// FIFO non-empty; its byte appears on data_out with vld_out=1 one cycle later.
module router_egress_arbiter
  import router_pkg::*;
#(
  parameter int DW      = 8,
  parameter int TIMEOUT = 30
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             empty_0,
  input  logic             empty_1,
  input  logic             empty_2,
  input  logic [DW-1:0]    data_in_0,
  input  logic [DW-1:0]    data_in_1,
  input  logic [DW-1:0]    data_in_2,
  input  logic             ready_in,
  output logic             read_enb_0,
  output logic             read_enb_1,
  output logic             read_enb_2,
  output logic [DW-1:0]    data_out,
  output logic             vld_out,
  output logic             sop_out,
  output logic             eop_out,
  output logic [1:0]       grant,
  output logic             abort_out,
  output logic             busy,
  output state_t           fsm_state,
  output logic [DW-2:0]    remaining,
  output logic [CNT_W-1:0] timeout_count
);

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [DW-2:0]    REM_ONE = (DW-1)'(1);

  state_t           state;
  state_t           state_n;
  logic [1:0]       last_grant;
  logic [1:0]       last_grant_n;
  logic [1:0]       grant_n;
  logic [DW-2:0]    remaining_n;
  logic [CNT_W-1:0] timeout_count_n;
  logic             vld_q;
  logic             abort_q;
  logic             abort_n;

  logic             empty_g;
  logic [DW-1:0]    din_g;
  logic             rd_window;
  logic             rd_issue;
  logic             timeout_hit;
  logic             pick_found;
  logic [1:0]       pick_idx;

  rr_pick3 u_pick (
    .req        ({~empty_2, ~empty_1, ~empty_0}),
    .last_grant (last_grant),
    .found      (pick_found),
    .idx        (pick_idx)
  );

  // With no owner the channel reads as empty, so no read can leak out.
  always_comb begin
    empty_g = 1'b1;
    din_g   = '0;
    case (grant)
      2'd0: begin empty_g = empty_0; din_g = data_in_0; end
      2'd1: begin empty_g = empty_1; din_g = data_in_1; end
      2'd2: begin empty_g = empty_2; din_g = data_in_2; end
      default: begin empty_g = 1'b1; din_g = '0; end
    endcase
  end

  assign rd_window   = (state == RD_HDR) || (state == RD_BODY);
  assign rd_issue    = rd_window && ready_in && !empty_g;
  assign timeout_hit = rd_window && empty_g && (timeout_count == TO_LAST);

  assign read_enb_0 = rd_issue && (grant == 2'd0);
  assign read_enb_1 = rd_issue && (grant == 2'd1);
  assign read_enb_2 = rd_issue && (grant == 2'd2);

  assign vld_out   = vld_q;
  assign sop_out   = vld_q && (state == CAP_HDR);
  assign eop_out   = vld_q && (state == LAST);
  assign data_out  = vld_q ? din_g : '0;
  assign abort_out = abort_q;
  assign busy      = (state != ARB);
  assign fsm_state = state;

  always_comb begin
    state_n         = state;
    grant_n         = grant;
    last_grant_n    = last_grant;
    remaining_n     = remaining;
    timeout_count_n = '0;
    abort_n         = 1'b0;

    // Stall counter: runs on empty cycles, holds on sink backpressure.
    if (rd_window) begin
      if (rd_issue) begin
        timeout_count_n = '0;
      end else if (empty_g) begin
        timeout_count_n = timeout_count + 1'b1;
      end else begin
        timeout_count_n = timeout_count;
      end
    end

    case (state)
      ARB: begin
        if (pick_found) begin
          grant_n = pick_idx;
          state_n = RD_HDR;
        end
      end
      RD_HDR: begin
        if (rd_issue) begin
          state_n = CAP_HDR;
        end
      end
      CAP_HDR: begin
        remaining_n = {1'b0, din_g[DW-1:LEN_LSB]} + REM_ONE;
        state_n     = RD_BODY;
      end
      RD_BODY: begin
        if (rd_issue) begin
          remaining_n = remaining - REM_ONE;
          if (remaining == REM_ONE) begin
            state_n = LAST;
          end
        end
      end
      LAST: begin
        last_grant_n = grant;
        grant_n      = GRANT_NONE;
        state_n      = ARB;
      end
      default: begin
        grant_n = GRANT_NONE;
        state_n = ARB;
      end
    endcase

    // The FIFO keeps its stale bytes; its own soft reset clears them.
    if (timeout_hit) begin
      abort_n         = 1'b1;
      last_grant_n    = grant;
      grant_n         = GRANT_NONE;
      state_n         = ARB;
      timeout_count_n = '0;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state         <= ARB;
      grant         <= GRANT_NONE;
      last_grant    <= 2'd2;
      remaining     <= '0;
      timeout_count <= '0;
      vld_q         <= 1'b0;
      abort_q       <= 1'b0;
    end else begin
      state         <= state_n;
      grant         <= grant_n;
      last_grant    <= last_grant_n;
      remaining     <= remaining_n;
      timeout_count <= timeout_count_n;
      vld_q         <= rd_issue;
      abort_q       <= abort_n;
    end
  end

endmodule

// File: tb/tb_router_egress_arbiter.sv
// Directed bench for router_egress_arbiter: three FIFO models feed the DUT and
// a monitor collects the egress stream for comparison against expected bytes.
module tb_router_egress_arbiter;
  import router_pkg::*;

  logic             clock = 1'b0;
  logic             resetn = 1'b0;
  logic             empty_0 = 1'b1;
  logic             empty_1 = 1'b1;
  logic             empty_2 = 1'b1;
  logic [7:0]       data_in_0 = '0;
  logic [7:0]       data_in_1 = '0;
  logic [7:0]       data_in_2 = '0;
  logic             ready_in = 1'b0;
  logic             read_enb_0, read_enb_1, read_enb_2;
  logic [7:0]       data_out;
  logic             vld_out, sop_out, eop_out, abort_out, busy;
  logic [1:0]       grant;
  state_t           fsm_state;
  logic [6:0]       remaining;
  logic [CNT_W-1:0] timeout_count;

  router_egress_arbiter #(.DW(8), .TIMEOUT(30)) dut (
    .clock(clock), .resetn(resetn),
    .empty_0(empty_0), .empty_1(empty_1), .empty_2(empty_2),
    .data_in_0(data_in_0), .data_in_1(data_in_1), .data_in_2(data_in_2),
    .ready_in(ready_in),
    .read_enb_0(read_enb_0), .read_enb_1(read_enb_1), .read_enb_2(read_enb_2),
    .data_out(data_out), .vld_out(vld_out), .sop_out(sop_out), .eop_out(eop_out),
    .grant(grant), .abort_out(abort_out), .busy(busy),
    .fsm_state(fsm_state), .remaining(remaining), .timeout_count(timeout_count)
  );

  always #5 clock = ~clock;

  // FIFO models: registered read data, empty flag updated on the clock edge.
  logic [7:0] q0[$], q1[$], q2[$];
  always @(posedge clock) begin
    if (read_enb_0) data_in_0 <= q0.pop_front();
    if (read_enb_1) data_in_1 <= q1.pop_front();
    if (read_enb_2) data_in_2 <= q2.pop_front();
    empty_0 <= (q0.size() == 0);
    empty_1 <= (q1.size() == 0);
    empty_2 <= (q2.size() == 0);
  end

  // Stream records are {grant, sop, eop, byte}.
  logic [11:0] exp_q[$];
  logic [11:0] got_q[$];
  int          got_cyc[$];
  int          cyc = 0;
  int          rd_cnt[3];
  int          abort_cnt = 0;
  int          bad_rd = 0;
  int          onehot_err = 0;
  int          n_checks = 0;
  int          n_pass = 0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (resetn) begin
      if (vld_out) begin
        got_q.push_back({grant, sop_out, eop_out, data_out});
        got_cyc.push_back(cyc);
      end
      if (read_enb_0) rd_cnt[0]++;
      if (read_enb_1) rd_cnt[1]++;
      if (read_enb_2) rd_cnt[2]++;
      if (abort_out) abort_cnt++;
      if ((read_enb_0 && empty_0) || (read_enb_1 && empty_1) || (read_enb_2 && empty_2)) bad_rd++;
      if (int'(read_enb_0) + int'(read_enb_1) + int'(read_enb_2) > 1) onehot_err++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_fifo(input int ch, input logic [7:0] b);
    case (ch)
      0: q0.push_back(b);
      1: q1.push_back(b);
      default: q2.push_back(b);
    endcase
  endtask

  // Loads header, up to avail payload bytes, and parity only if complete.
  task automatic load_pkt(input int ch, input logic [7:0] hdr, input logic [7:0] first, input int avail);
    int len;
    logic [7:0] b;
    logic [7:0] par;
    len = int'(hdr[7:2]);
    par = hdr;
    push_fifo(ch, hdr);
    exp_q.push_back({2'(ch), 2'b10, hdr});
    for (int i = 0; i < len && i < avail; i++) begin
      b = first + 8'(i * 17);
      par = par ^ b;
      push_fifo(ch, b);
      exp_q.push_back({2'(ch), 2'b00, b});
    end
    if (avail >= len) begin
      push_fifo(ch, par);
      exp_q.push_back({2'(ch), 2'b01, par});
    end
  endtask

  task automatic clear_mon();
    got_q.delete();
    got_cyc.delete();
    exp_q.delete();
    for (int i = 0; i < 3; i++) rd_cnt[i] = 0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (!busy && q0.size() == 0 && q1.size() == 0 && q2.size() == 0 &&
          empty_0 && empty_1 && empty_2) begin
        ok = 1'b1;
        break;
      end
    end
    @(negedge clock);
  endtask

  task automatic apply_reset();
    resetn = 1'b0;
    repeat (2) @(negedge clock);
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clock);
    @(negedge clock);
    n_checks++;
    if ({read_enb_0, read_enb_1, read_enb_2, vld_out, sop_out, eop_out, abort_out, busy} !== 8'h00)
      $display("FAIL reset_flags got %b want 00000000",
               {read_enb_0, read_enb_1, read_enb_2, vld_out, sop_out, eop_out, abort_out, busy});
    else n_pass++;
    n_checks++;
    if (grant !== 2'd3) $display("FAIL reset_grant got %0d want 3", grant); else n_pass++;
    n_checks++;
    if (fsm_state !== ARB || remaining !== 7'd0 || timeout_count !== '0 || data_out !== 8'h00)
      $display("FAIL reset_regs got state=%0d rem=%0d to=%0d data=%h want 0 0 0 00",
               fsm_state, remaining, timeout_count, data_out);
    else n_pass++;
    resetn = 1'b1;
  endtask

  task automatic test_single_packet();
    bit ok;
    clear_mon();
    ready_in = 1'b1;
    load_pkt(0, 8'h0C, 8'h11, 99);
    wait_idle(200, ok);
    n_checks++;
    if (!ok) $display("FAIL single_idle got timeout want idle"); else n_pass++;
    n_checks++;
    if (rd_cnt[0] !== 5 || rd_cnt[1] !== 0 || rd_cnt[2] !== 0)
      $display("FAIL single_reads got %0d/%0d/%0d want 5/0/0", rd_cnt[0], rd_cnt[1], rd_cnt[2]);
    else n_pass++;
    n_checks++;
    if (got_q.size() !== exp_q.size()) $display("FAIL single_len got %0d want %0d", got_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) $display("FAIL single_byte%0d got %h want %h", i, got_q[i], exp_q[i]);
      else n_pass++;
    end
    if (got_cyc.size() == 5) begin
      n_checks++;
      if (got_cyc[4] - got_cyc[0] !== 5 || got_cyc[3] - got_cyc[1] !== 2)
        $display("FAIL single_timing got span %0d/%0d want 5/2", got_cyc[4] - got_cyc[0], got_cyc[3] - got_cyc[1]);
      else n_pass++;
    end
    n_checks++;
    if (grant !== 2'd3 || fsm_state !== ARB || busy !== 1'b0)
      $display("FAIL single_end got grant=%0d state=%0d busy=%b want 3 0 0", grant, fsm_state, busy);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    bit ok;
    apply_reset();
    clear_mon();
    load_pkt(0, 8'h04, 8'hA0, 99);
    load_pkt(1, 8'h05, 8'hB0, 99);
    load_pkt(2, 8'h06, 8'hC0, 99);
    wait_idle(300, ok);
    n_checks++;
    if (!ok) $display("FAIL rr1_idle got timeout want idle"); else n_pass++;
    n_checks++;
    if (got_q.size() !== exp_q.size()) $display("FAIL rr1_len got %0d want %0d", got_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) $display("FAIL rr1_byte%0d got %h want %h", i, got_q[i], exp_q[i]);
      else n_pass++;
    end
    clear_mon();
    load_pkt(0, 8'h04, 8'h40, 99);
    load_pkt(2, 8'h06, 8'h60, 99);
    wait_idle(300, ok);
    n_checks++;
    if (!ok) $display("FAIL rr2_idle got timeout want idle"); else n_pass++;
    n_checks++;
    if (got_q.size() !== exp_q.size()) $display("FAIL rr2_len got %0d want %0d", got_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) $display("FAIL rr2_byte%0d got %h want %h", i, got_q[i], exp_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_zero_length();
    bit ok;
    clear_mon();
    load_pkt(1, 8'h01, 8'h00, 99);
    for (int i = 0; i < 50 && fsm_state !== RD_BODY; i++) @(negedge clock);
    n_checks++;
    if (fsm_state !== RD_BODY || remaining !== 7'd1)
      $display("FAIL zero_remaining got state=%0d rem=%0d want 3 1", fsm_state, remaining);
    else n_pass++;
    wait_idle(200, ok);
    n_checks++;
    if (!ok || rd_cnt[1] !== 2) $display("FAIL zero_reads got %0d ok=%b want 2", rd_cnt[1], ok); else n_pass++;
    n_checks++;
    if (got_q.size() !== exp_q.size()) $display("FAIL zero_len got %0d want %0d", got_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) $display("FAIL zero_byte%0d got %h want %h", i, got_q[i], exp_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_ready_gap();
    bit ok;
    clear_mon();
    load_pkt(0, 8'h10, 8'h21, 99);
    for (int i = 0; i < 50 && fsm_state !== RD_BODY; i++) @(negedge clock);
    n_checks++;
    if (fsm_state !== RD_BODY || read_enb_0 !== 1'b1)
      $display("FAIL gap_start got state=%0d rd=%b want 3 1", fsm_state, read_enb_0);
    else n_pass++;
    @(posedge clock); #1 ready_in = 1'b0;
    @(negedge clock);
    n_checks++;
    if ({read_enb_0, vld_out} !== 2'b01 || timeout_count !== '0)
      $display("FAIL gap_c1 got rd=%b vld=%b to=%0d want 0 1 0", read_enb_0, vld_out, timeout_count);
    else n_pass++;
    @(posedge clock); #1 ready_in = 1'b0;
    @(negedge clock);
    n_checks++;
    if ({read_enb_0, vld_out} !== 2'b00 || timeout_count !== '0)
      $display("FAIL gap_c2 got rd=%b vld=%b to=%0d want 0 0 0", read_enb_0, vld_out, timeout_count);
    else n_pass++;
    @(posedge clock); #1 ready_in = 1'b1;
    @(negedge clock);
    n_checks++;
    if ({read_enb_0, vld_out} !== 2'b10)
      $display("FAIL gap_c3 got rd=%b vld=%b want 1 0", read_enb_0, vld_out);
    else n_pass++;
    wait_idle(200, ok);
    n_checks++;
    if (!ok || rd_cnt[0] !== 6) $display("FAIL gap_reads got %0d ok=%b want 6", rd_cnt[0], ok); else n_pass++;
    n_checks++;
    if (got_q.size() !== exp_q.size()) $display("FAIL gap_len got %0d want %0d", got_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) $display("FAIL gap_byte%0d got %h want %h", i, got_q[i], exp_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int n;
    clear_mon();
    load_pkt(2, 8'h14, 8'h31, 2);
    for (int i = 0; i < 50 && grant !== 2'd2; i++) @(negedge clock);
    load_pkt(0, 8'h04, 8'h51, 99);
    for (int i = 0; i < 50 && !(fsm_state === RD_BODY && empty_2 === 1'b1); i++) @(negedge clock);
    n_checks++;
    if (fsm_state !== RD_BODY || grant !== 2'd2 || timeout_count !== '0)
      $display("FAIL to_stall got state=%0d grant=%0d to=%0d want 3 2 0", fsm_state, grant, timeout_count);
    else n_pass++;
    n = 0;
    while (abort_out !== 1'b1 && n < 100) begin
      @(negedge clock);
      n++;
    end
    n_checks++;
    if (n !== 30) $display("FAIL to_cycles got %0d want 30", n); else n_pass++;
    n_checks++;
    if (grant !== 2'd3 || fsm_state !== ARB)
      $display("FAIL to_state got grant=%0d state=%0d want 3 0", grant, fsm_state);
    else n_pass++;
    @(negedge clock);
    n_checks++;
    if (abort_out !== 1'b0) $display("FAIL to_pulse got %b want 0", abort_out); else n_pass++;
    wait_idle(200, ok);
    n_checks++;
    if (!ok || rd_cnt[2] !== 3 || rd_cnt[0] !== 3)
      $display("FAIL to_reads got %0d/%0d ok=%b want 3/3", rd_cnt[2], rd_cnt[0], ok);
    else n_pass++;
    n_checks++;
    if (got_q.size() !== exp_q.size()) $display("FAIL to_len got %0d want %0d", got_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) $display("FAIL to_byte%0d got %h want %h", i, got_q[i], exp_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    clear_mon();
    load_pkt(1, 8'h18, 8'h71, 99);
    for (int i = 0; i < 50 && fsm_state !== RD_BODY; i++) @(negedge clock);
    @(posedge clock);
    #2;
    n_checks++;
    if (read_enb_1 !== 1'b1 || vld_out !== 1'b1)
      $display("FAIL arst_pre got rd=%b vld=%b want 1 1", read_enb_1, vld_out);
    else n_pass++;
    resetn = 1'b0;
    #1;
    n_checks++;
    if ({read_enb_0, read_enb_1, read_enb_2, vld_out, busy} !== 5'b00000 || grant !== 2'd3)
      $display("FAIL arst_now got flags=%b grant=%0d want 00000 3",
               {read_enb_0, read_enb_1, read_enb_2, vld_out, busy}, grant);
    else n_pass++;
    q1.delete();
    repeat (2) @(negedge clock);
    clear_mon();
    load_pkt(0, 8'h08, 8'h81, 99);
    load_pkt(2, 8'h04, 8'h91, 99);
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    for (int i = 0; i < 20 && grant === 2'd3; i++) @(negedge clock);
    n_checks++;
    if (grant !== 2'd0) $display("FAIL arst_first got %0d want 0", grant); else n_pass++;
    wait_idle(300, ok);
    n_checks++;
    if (got_q.size() !== exp_q.size() || !ok)
      $display("FAIL arst_len got %0d ok=%b want %0d", got_q.size(), ok, exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) $display("FAIL arst_byte%0d got %h want %h", i, got_q[i], exp_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_invariants();
    n_checks++;
    if (bad_rd !== 0 || onehot_err !== 0)
      $display("FAIL inv_reads got bad=%0d multi=%0d want 0 0", bad_rd, onehot_err);
    else n_pass++;
    n_checks++;
    if (abort_cnt !== 1) $display("FAIL inv_aborts got %0d want 1", abort_cnt); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_round_robin();
    test_zero_length();
    test_ready_gap();
    test_timeout();
    test_async_reset();
    test_invariants();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
